// File: rtl/led_target_engine.sv
// One round of the reflex game: countdown timer, score, and a
// pseudo-randomly moving one-hot target LED scored against player switch rises.
module led_target_engine #(
    parameter int          N_LEDS       = 16,
    parameter int          GAME_SECS    = 30,
    parameter int          TARGET_TICKS = 3,
    parameter int          SCORE_W      = 6,
    parameter int          PENALTY      = 1,
    parameter int          RESET_LED    = 1,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               tick,
    input  logic [N_LEDS-1:0]  sw,
    output logic [N_LEDS-1:0]  led,
    output logic [5:0]         timer,
    output logic [SCORE_W-1:0] score,
    output logic               hit,
    output logic               miss,
    output logic               done,
    output logic [1:0]         dbg_state
);
    localparam int TW = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
    localparam logic [N_LEDS-1:0]  ONE       = N_LEDS'(1);
    localparam logic [N_LEDS-1:0]  IDLE_LED  = ONE << RESET_LED;
    localparam logic [TW-1:0]      LAST_IDX  = TW'(N_LEDS - 1);
    localparam logic [5:0]         GAME_T    = 6'(GAME_SECS);
    localparam logic [3:0]         AGE_MAX   = 4'(TARGET_TICKS);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DONE} state_t;

    state_t             state_q;
    logic [15:0]        lfsr_q;
    logic [TW-1:0]      target_q;
    logic [3:0]         age_q;
    logic [N_LEDS-1:0]  sync1_q, sync2_q, dly_q, rise_q;
    logic [N_LEDS-1:0]  led_q;
    logic [5:0]         timer_q;
    logic [SCORE_W-1:0] score_q;
    logic               hit_q, miss_q, done_q;

    logic [TW-1:0]      cand_d, pick_d;
    logic [3:0]         age_d;
    logic               is_hit_d, is_miss_d;

    // Candidate is bumped by one when it collides, so a pick always moves the target.
    always_comb begin
        cand_d    = TW'(lfsr_q % 16'(N_LEDS));
        pick_d    = cand_d;
        if (cand_d == target_q) begin
            pick_d = (cand_d == LAST_IDX) ? '0 : cand_d + TW'(1);
        end
        age_d     = age_q + 4'd1;
        is_hit_d  = (rise_q == (ONE << target_q));
        is_miss_d = (rise_q != '0) && !is_hit_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            lfsr_q   <= LFSR_SEED;
            target_q <= '0;
            age_q    <= '0;
            sync1_q  <= '0;
            sync2_q  <= '0;
            dly_q    <= '0;
            rise_q   <= '0;
            led_q    <= IDLE_LED;
            timer_q  <= '0;
            score_q  <= '0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
            sync1_q <= sw;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
            rise_q  <= sync2_q & ~dly_q;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;

            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q  <= S_PLAY;
                        timer_q  <= GAME_T;
                        score_q  <= '0;
                        target_q <= pick_d;
                        age_q    <= '0;
                        led_q    <= ONE << pick_d;
                        done_q   <= 1'b0;
                    end
                end
                S_PLAY: begin
                    hit_q  <= is_hit_d;
                    miss_q <= is_miss_d;
                    if (is_hit_d) begin
                        if (score_q != SCORE_MAX) score_q <= score_q + SCORE_W'(1);
                    end else if (is_miss_d && PENALTY != 0) begin
                        if (score_q != '0) score_q <= score_q - SCORE_W'(1);
                    end

                    // A hit retargets and clears the age even if the tick also times out.
                    if (is_hit_d || (tick && age_d == AGE_MAX)) begin
                        target_q <= pick_d;
                        age_q    <= '0;
                        led_q    <= ONE << pick_d;
                    end else if (tick) begin
                        age_q <= age_d;
                    end

                    if (tick) begin
                        timer_q <= timer_q - 6'd1;
                        if (timer_q == 6'd1) begin
                            state_q <= S_DONE;
                            led_q   <= '1;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    led_q   <= IDLE_LED;
                end
            endcase
        end
    end

    assign led       = led_q;
    assign timer     = timer_q;
    assign score     = score_q;
    assign hit       = hit_q;
    assign miss      = miss_q;
    assign done      = done_q;
    assign dbg_state = state_q;
endmodule
